// File: rtl/pipe_stage_skid_pkg.sv
// Shared defaults for the skid-buffered writeback pipeline stage.
package pipe_stage_skid_pkg;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_NUM_LANES = 2;
  localparam int DEF_CTRL_W    = 1;
  localparam int DEF_REG_W     = 4;
  localparam logic [DEF_CTRL_W-1:0] CTRL_NONE = '0;
endpackage

// File: rtl/pipe_stage_skid_entry.sv
// One held slot (valid + payload). Clear kills only the valid bit; payload loads only on load.
module pipe_entry #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 clear,
  input  logic [PAYLOAD_W-1:0] d,
  output logic                 vld,
  output logic [PAYLOAD_W-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        vld <= 1'b0;
    else if (clear) vld <= 1'b0;
    else if (load)  vld <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (load) q <= d;
  end
endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid stage: M drives the outputs, S absorbs the beat accepted while M stalls.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int CTRL_W    = DEF_CTRL_W,
  parameter int REG_W     = DEF_REG_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CTRL_W-1:0]           in_ctrl,
  input  logic [NUM_LANES*DATA_W-1:0] in_data,
  input  logic [REG_W-1:0]            in_wreg,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CTRL_W-1:0]           out_ctrl,
  output logic [NUM_LANES*DATA_W-1:0] out_data,
  output logic [REG_W-1:0]            out_wreg,
  output logic [1:0]                  occupancy
);
  localparam int DW = NUM_LANES*DATA_W;
  localparam int PW = CTRL_W + REG_W + DW;

  logic [PW-1:0] in_pl, m_pl, s_pl, m_d;
  logic m_vld, s_vld, accept, pop;
  logic m_load, m_clr, s_load, s_clr;

  assign in_pl  = {in_ctrl, in_wreg, in_data};
  assign accept = in_valid & in_ready;
  assign pop    = m_vld & out_ready;

  // Flush suppresses every load so held payloads stay intact; only valid bits drop.
  always_comb begin
    m_load = 1'b0;
    m_clr  = 1'b0;
    s_load = 1'b0;
    s_clr  = 1'b0;
    m_d    = s_vld ? s_pl : in_pl;
    if (!m_vld) begin
      m_load = accept;
    end else if (pop) begin
      if (s_vld) begin
        m_load = 1'b1;
        s_clr  = 1'b1;
      end else if (accept) begin
        m_load = 1'b1;
      end else begin
        m_clr  = 1'b1;
      end
    end else begin
      s_load = accept;
    end
    if (flush) begin
      m_load = 1'b0;
      s_load = 1'b0;
      m_clr  = 1'b1;
      s_clr  = 1'b1;
    end
  end

  pipe_entry #(.PAYLOAD_W(PW)) u_m (
    .clk(clk), .rst(rst), .load(m_load), .clear(m_clr), .d(m_d), .vld(m_vld), .q(m_pl)
  );

  pipe_entry #(.PAYLOAD_W(PW)) u_s (
    .clk(clk), .rst(rst), .load(s_load), .clear(s_clr), .d(in_pl), .vld(s_vld), .q(s_pl)
  );

  assign in_ready  = ~s_vld;
  assign out_valid = m_vld;
  assign out_data  = m_pl[DW-1:0];
  assign out_wreg  = m_pl[DW +: REG_W];
  assign out_ctrl  = m_vld ? m_pl[PW-1 -: CTRL_W] : CTRL_W'(CTRL_NONE);
  assign occupancy = {1'b0, m_vld} + {1'b0, s_vld};

  a_no_orphan_skid: assert property (@(posedge clk) disable iff (rst) !(s_vld && !m_vld));
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: queue of expected payloads, per-scenario tasks.
module tb_pipe_stage_skid;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [0:0]  in_ctrl, out_ctrl;
  logic [31:0] in_data, out_data;
  logic [3:0]  in_wreg, out_wreg;
  logic [1:0]  occupancy;

  int n_cmp = 0;
  int n_err = 0;
  logic [36:0] sb[$];

  always #5 clk = ~clk;

  pipe_stage_skid dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_data(in_data), .in_wreg(in_wreg), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data), .out_wreg(out_wreg),
    .occupancy(occupancy)
  );

  // Sample at negedge against the model, update the model, advance past the posedge.
  task automatic tick();
    logic acc, pp;
    logic [36:0] got;
    @(negedge clk);
    acc = in_valid && (sb.size() < 2);
    pp  = out_ready && (sb.size() > 0);
    got = {out_ctrl, out_wreg, out_data};
    n_cmp++;
    if (occupancy !== 2'(sb.size())) begin
      n_err++; $display("FAIL occupancy: got %0d want %0d", occupancy, sb.size());
    end
    n_cmp++;
    if (in_ready !== (sb.size() < 2)) begin
      n_err++; $display("FAIL in_ready: got %b want %b", in_ready, sb.size() < 2);
    end
    n_cmp++;
    if (out_valid !== (sb.size() > 0)) begin
      n_err++; $display("FAIL out_valid: got %b want %b", out_valid, sb.size() > 0);
    end
    if (sb.size() > 0) begin
      n_cmp++;
      if (got !== sb[0]) begin
        n_err++; $display("FAIL payload: got %h want %h", got, sb[0]);
      end
    end else begin
      n_cmp++;
      if (out_ctrl !== 1'b0) begin
        n_err++; $display("FAIL bubble_ctrl: got %b want 0", out_ctrl);
      end
    end
    if (flush) sb.delete();
    else begin
      if (pp) void'(sb.pop_front());
      if (acc) sb.push_back({in_ctrl, in_wreg, in_data});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; flush = 0; out_ready = 0;
    in_ctrl = 0; in_data = 0; in_wreg = 0;
  endtask

  task automatic drain();
    in_valid = 0; out_ready = 1; flush = 0;
    for (int i = 0; i < 8 && sb.size() > 0; i++) tick();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL drain: %0d entries left want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    #1;
    n_cmp++;
    if ({out_valid, out_ctrl, out_data, out_wreg, occupancy, in_ready} !== {1'b0, 1'b0, 32'h0, 4'h0, 2'd0, 1'b1}) begin
      n_err++; $display("FAIL reset_state: v=%b c=%b d=%h w=%h occ=%0d rdy=%b want 0/0/0/0/0/1",
                        out_valid, out_ctrl, out_data, out_wreg, occupancy, in_ready);
    end
    @(posedge clk); @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    in_valid = 1; in_data = 32'h1234_ABCD; in_wreg = 4'd3; in_ctrl = 1'b1; out_ready = 1;
    tick();
    n_cmp++;
    if ({out_valid, out_ctrl, out_wreg, out_data, occupancy} !== {1'b1, 1'b1, 4'd3, 32'h1234_ABCD, 2'd1}) begin
      n_err++; $display("FAIL single_latency: v=%b c=%b w=%h d=%h occ=%0d want 1/1/3/1234abcd/1",
                        out_valid, out_ctrl, out_wreg, out_data, occupancy);
    end
    in_valid = 0;
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1; in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      in_data = 32'(i); in_wreg = 4'(i); in_ctrl = 1'(i);
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_err++; $display("FAIL stream_ready: cycle %0d got %b want 1", i, in_ready);
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
        n_err++; $display("FAIL stream_order: cycle %0d got v=%b d=%h want 1/%h", i, out_valid, out_data, i);
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 0; in_valid = 1;
    in_data = 32'hAAAA_0001; in_wreg = 4'hA; in_ctrl = 1; tick();
    in_data = 32'hBBBB_0002; in_wreg = 4'hB; in_ctrl = 0; tick();
    in_valid = 0;
    n_cmp++;
    if ({occupancy, in_ready, out_data} !== {2'd2, 1'b0, 32'hAAAA_0001}) begin
      n_err++; $display("FAIL skid_full: occ=%0d rdy=%b d=%h want 2/0/aaaa0001", occupancy, in_ready, out_data);
    end
    out_ready = 1;
    tick();
    n_cmp++;
    if ({in_ready, out_data, occupancy} !== {1'b1, 32'hBBBB_0002, 2'd1}) begin
      n_err++; $display("FAIL skid_pop: rdy=%b d=%h occ=%0d want 1/bbbb0002/1", in_ready, out_data, occupancy);
    end
    drain();
  endtask

  task automatic test_flush();
    out_ready = 0; in_valid = 1;
    in_data = 32'h1111_1111; in_ctrl = 1; tick();
    in_data = 32'h2222_2222; tick();
    in_data = 32'h3333_3333; flush = 1; tick();
    flush = 0; in_valid = 0;
    n_cmp++;
    if ({out_valid, out_ctrl, occupancy, in_ready} !== {1'b0, 1'b0, 2'd0, 1'b1}) begin
      n_err++; $display("FAIL flush: v=%b c=%b occ=%0d rdy=%b want 0/0/0/1", out_valid, out_ctrl, occupancy, in_ready);
    end
    out_ready = 1;
    tick(); tick();
  endtask

  task automatic test_async_reset();
    out_ready = 0; in_valid = 1; in_ctrl = 1; in_wreg = 4'h7;
    in_data = 32'h5555_0001; tick();
    in_data = 32'h5555_0002; tick();
    in_valid = 0;
    #2 rst = 1;
    #1;
    n_cmp++;
    if ({out_valid, out_ctrl, out_data, out_wreg, occupancy, in_ready} !== {1'b0, 1'b0, 32'h0, 4'h0, 2'd0, 1'b1}) begin
      n_err++; $display("FAIL async_reset: v=%b c=%b d=%h w=%h occ=%0d rdy=%b want 0/0/0/0/0/1",
                        out_valid, out_ctrl, out_data, out_wreg, occupancy, in_ready);
    end
    sb.delete();
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    in_valid = 1; out_ready = 1; in_data = 32'hCAFE_0042; in_wreg = 4'h2; in_ctrl = 1;
    tick();
    in_valid = 0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 32'hCAFE_0042) begin
      n_err++; $display("FAIL post_reset_push: v=%b d=%h want 1/cafe0042", out_valid, out_data);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_data   = $urandom;
      in_wreg   = 4'($urandom);
      in_ctrl   = 1'($urandom);
      tick();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
